f1_reaction_timer: RTL and testbench

- Control stage wrapped around the F1 start-light sequencer; it is both that sequencer's upstream and its downstream.
- Upstream role: gates the sequencer's enable so the lights build up only when a round is running.
- Downstream role: watches the light bus for all-lights-on, waits a pseudo-random number of ticks, then blanks the lights. It measures the player's reaction time in ticks until the button is pressed and flags jump starts.

---
 rtl/f1_pkg.sv | 7 +
 rtl/f1_lfsr.sv | 14 +
 rtl/f1_reaction_timer.sv | 94 +++++++++
 tb/tb_f1_reaction_timer.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/f1_pkg.sv
// f1_pkg: shared state encoding and constants for the reaction timer
package f1_pkg;
  typedef enum logic [2:0] {IDLE, SEQ, DELAY, REACT, DONE} state_t;
  localparam int LFSR_TAP_A = 1;
  localparam int LFSR_TAP_B = 2;
  localparam logic [63:0] LIGHTS_ALL_ON = '1;
endpackage

// File: rtl/f1_lfsr.sv
// f1_lfsr: free-running Fibonacci LFSR (x^7+x^6+1 at the default width), never zero from a nonzero seed
module f1_lfsr import f1_pkg::*; #(
  parameter int LFSR_W = 7,
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(1)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [LFSR_W-1:0] q
);
  // shift every clock so the latched delay depends on when the player acts
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= LFSR_SEED;
    else q <= {q[LFSR_W-2:0], q[LFSR_W-LFSR_TAP_A] ^ q[LFSR_W-LFSR_TAP_B]};
endmodule

// File: rtl/f1_reaction_timer.sv
// f1_reaction_timer: gates the start-light sequencer, holds a random delay, then times the button press; F1_RT_BTN_SYNC_EN adds a 2-flop button synchronizer
module f1_reaction_timer import f1_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16,
  parameter int LFSR_W = 7,
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic [WIDTH-1:0]  lights,
  input  logic              btn,
  output logic              fsm_en,
  output logic              lights_off,
  output logic              lights_clr,
  output logic [CNT_W-1:0]  react_cnt,
  output logic              result_valid,
  output logic              jump_start,
  output logic [LFSR_W-1:0] delay_val
);
  state_t state, nxt;
  logic btn_in, btn_q, btn_edge, all_on;
  logic [LFSR_W-1:0] lfsr, dly_cnt;
`ifdef F1_RT_BTN_SYNC_EN
  logic [1:0] btn_sync;
  // two-flop synchronizer for the asynchronous button
  always_ff @(posedge clk or posedge rst)
    if (rst) btn_sync <= '0;
    else btn_sync <= {btn_sync[0], btn};
  assign btn_in = btn_sync[1];
`else
  assign btn_in = btn;
`endif
  assign btn_edge = btn_in & ~btn_q;
  assign all_on = lights == LIGHTS_ALL_ON[WIDTH-1:0];
  f1_lfsr #(.LFSR_W(LFSR_W), .LFSR_SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst(rst), .q(lfsr));
  // previous button level for rising-edge detection
  always_ff @(posedge clk or posedge rst)
    if (rst) btn_q <= 1'b0;
    else btn_q <= btn_in;
  // state register plus the one-cycle result pulses on DONE entry
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      result_valid <= 1'b0;
      lights_clr <= 1'b0;
    end else begin
      state <= nxt;
      result_valid <= nxt == DONE && state != DONE;
      lights_clr <= nxt == DONE && state != DONE;
    end
  // next state; the button always wins over a coincident tick or full lights
  always_comb begin
    nxt = state;
    fsm_en = state == SEQ && tick && !all_on;
    lights_off = state == REACT || (state == DONE && !jump_start);
    case (state)
      IDLE:    nxt = btn_edge ? SEQ : IDLE;
      SEQ:     nxt = btn_edge ? DONE : all_on ? DELAY : SEQ;
      DELAY:   nxt = btn_edge ? DONE : (tick && dly_cnt == LFSR_W'(1)) ? REACT : DELAY;
      REACT:   nxt = btn_edge ? DONE : REACT;
      DONE:    nxt = btn_edge ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  // delay latch/countdown, saturating reaction counter and jump-start flag
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      react_cnt <= '0;
      jump_start <= 1'b0;
      delay_val <= '0;
      dly_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (btn_edge) begin
          react_cnt <= '0;
          jump_start <= 1'b0;
        end
        SEQ: if (btn_edge) begin
          jump_start <= 1'b1;
          react_cnt <= '0;
        end else if (all_on) begin
          delay_val <= lfsr;
          dly_cnt <= lfsr;
        end
        DELAY: if (btn_edge) begin
          jump_start <= 1'b1;
          react_cnt <= '0;
        end else if (tick) dly_cnt <= dly_cnt - LFSR_W'(1);
        REACT: if (tick && !btn_edge && react_cnt != '1) react_cnt <= react_cnt + CNT_W'(1);
        default: ;
      endcase
    end
endmodule

// File: tb/tb_f1_reaction_timer.sv
// tb_f1_reaction_timer: randomized rounds against a timeline model of the reaction-timer rules
module tb_f1_reaction_timer;
`ifdef F1_RT_BTN_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int M_IDLE = 0, M_SEQ = 1, M_DELAY = 2, M_REACT = 3, M_DONE = 4;
  logic clk = 0, rst = 1, tick = 0, btn = 0;
  logic [7:0] lights;
  logic fsm_en, lights_off, lights_clr, result_valid, jump_start;
  logic [15:0] react_cnt;
  logic [6:0] delay_val;
  logic fsm_en_s, lights_off_s, lights_clr_s, result_valid_s, jump_start_s;
  logic [3:0] react_cnt_s;
  logic [6:0] delay_val_s;
  int tests = 0, fails = 0;
  int ph, nl, dly, dval, rc, lf, tc, tp, en_cnt;
  bit jmp, first;
  bit bh [0:3];

  f1_reaction_timer dut (.clk(clk), .rst(rst), .tick(tick), .lights(lights), .btn(btn),
    .fsm_en(fsm_en), .lights_off(lights_off), .lights_clr(lights_clr), .react_cnt(react_cnt),
    .result_valid(result_valid), .jump_start(jump_start), .delay_val(delay_val));
  f1_reaction_timer #(.CNT_W(4)) dut_s (.clk(clk), .rst(rst), .tick(tick), .lights(lights), .btn(btn),
    .fsm_en(fsm_en_s), .lights_off(lights_off_s), .lights_clr(lights_clr_s), .react_cnt(react_cnt_s),
    .result_valid(result_valid_s), .jump_start(jump_start_s), .delay_val(delay_val_s));

  always #5 clk = ~clk;

  always @(posedge clk or posedge rst)
    if (rst) lights <= '0;
    else if (lights_clr) lights <= '0;
    else if (fsm_en) lights <= {lights[6:0], 1'b1};

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic mreset();
    ph = M_IDLE; nl = 0; dly = 0; dval = 0; rc = 0; lf = 1; jmp = 0; first = 0; tc = 0; en_cnt = 0;
    for (int k = 0; k < 4; k++) bh[k] = 0;
  endtask

  task automatic cyc_t(input bit b, input bit t);
    bit bedge, all_on, e_en, e_off, e_pulse;
    btn = b; tick = t;
    for (int k = 3; k > 0; k--) bh[k] = bh[k-1];
    bh[0] = b;
    bedge = bh[LAT] && !bh[LAT+1];
    all_on = nl >= 8;
    e_en = ph == M_SEQ && t && !all_on;
    e_off = ph == M_REACT || (ph == M_DONE && !jmp);
    e_pulse = ph == M_DONE && first;
    @(negedge clk);
    if (fsm_en) en_cnt++;
    check("fsm_en", fsm_en, e_en);
    check("lights_off", lights_off, e_off);
    check("result_valid", result_valid, e_pulse);
    check("lights_clr", lights_clr, e_pulse);
    if (e_pulse) begin
      check("react_cnt", react_cnt, rc);
      check("react_cnt_sat", react_cnt_s, rc > 15 ? 15 : rc);
      check("jump_start", jump_start, jmp);
      check("delay_val", delay_val, dval);
    end
    if (e_pulse) nl = 0;
    else if (e_en) nl++;
    case (ph)
      M_IDLE: if (bedge) begin ph = M_SEQ; rc = 0; jmp = 0; end
      M_SEQ:
        if (bedge) begin ph = M_DONE; jmp = 1; rc = 0; first = 1; end
        else if (all_on) begin ph = M_DELAY; dly = lf; dval = lf; end
      M_DELAY:
        if (bedge) begin ph = M_DONE; jmp = 1; rc = 0; first = 1; end
        else if (t) begin
          if (dly == 1) ph = M_REACT;
          else dly--;
        end
      M_REACT:
        if (bedge) begin ph = M_DONE; first = 1; end
        else if (t) rc++;
      default: begin first = 0; if (bedge) ph = M_IDLE; end
    endcase
    lf = ((lf << 1) & 7'h7f) | (((lf >> 6) ^ (lf >> 5)) & 1);
    @(posedge clk); #1;
  endtask

  task automatic cyc(input bit b);
    cyc_t(b, tc % tp == 0);
    tc++;
  endtask

  task automatic press(input int hold);
    repeat (hold) cyc(1);
    cyc(0);
  endtask

  task automatic wait_ph(input int p, input string tag);
    int n = 0;
    while (ph != p && n < 3000) begin cyc(0); n++; end
    if (n >= 3000) check(tag, ph, p);
  endtask

  task automatic exit_round();
    repeat (3) cyc(0);
    press(1);
    wait_ph(M_IDLE, "to_idle");
    cyc(0);
  endtask

  task automatic round_normal(input int n, input int hold);
    int g = 0;
    en_cnt = 0;
    press(hold);
    wait_ph(M_DELAY, "to_delay");
    check("seq_pulses", en_cnt, 8);
    wait_ph(M_REACT, "to_react");
    while (rc < n && g < 3000) begin cyc(0); g++; end
    press(hold);
    wait_ph(M_DONE, "to_done");
    check("norm_jump", jump_start, 0);
    check("norm_off", lights_off, 1);
    exit_round();
  endtask

  task automatic round_jump_seq(input int k);
    int g = 0;
    press(1);
    while (!(ph == M_SEQ && nl >= k) && g < 3000) begin cyc(0); g++; end
    press(1);
    wait_ph(M_DONE, "to_done_js");
    check("jump_flag", jump_start, 1);
    check("jump_cnt", react_cnt, 0);
    check("jump_off", lights_off, 0);
    exit_round();
  endtask

  task automatic round_jump_delay();
    press(1);
    wait_ph(M_DELAY, "to_delay_jd");
    repeat ($urandom_range(0, 3)) cyc(0);
    press(1 + $urandom_range(0, 3));
    wait_ph(M_DONE, "to_done_jd");
    exit_round();
  endtask

  task automatic round_final_tick();
    int g = 0;
    press(1);
    wait_ph(M_DELAY, "to_delay_ft");
    while (!(ph == M_DELAY && dly == 1) && g < 3000) begin cyc(0); g++; end
    for (int i = 0; i <= LAT; i++) cyc_t(1, i == LAT);
    cyc(0);
    wait_ph(M_DONE, "to_done_ft");
    check("final_tick_jump", jump_start, 1);
    check("final_tick_cnt", react_cnt, 0);
    exit_round();
  endtask

  task automatic round_react_tick();
    int g = 0, rb;
    press(1);
    wait_ph(M_REACT, "to_react_rt");
    while (rc < 3 && g < 3000) begin cyc(0); g++; end
    rb = rc;
    for (int i = 0; i <= LAT; i++) cyc_t(1, i == LAT);
    cyc(0);
    wait_ph(M_DONE, "to_done_rt");
    check("react_tick_excl", react_cnt, rb);
    exit_round();
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_fsm_en"}, fsm_en, 0);
    check({tag, "_lights_off"}, lights_off, 0);
    check({tag, "_lights_clr"}, lights_clr, 0);
    check({tag, "_result_valid"}, result_valid, 0);
    check({tag, "_react_cnt"}, react_cnt, 0);
    check({tag, "_jump_start"}, jump_start, 0);
    check({tag, "_delay_val"}, delay_val, 0);
  endtask

  initial begin
    mreset();
    tp = 4;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("rst");
    rst = 0;
    mreset();
    round_normal(25, 1);
    round_normal(25, 10);
    round_jump_seq(3);
    round_jump_delay();
    round_final_tick();
    round_react_tick();
    round_normal(20, 2);
    check("sat_hold", react_cnt_s, 15);
    check("unsat_hold", react_cnt, 20);
    press(1);
    wait_ph(M_REACT, "to_react_mid");
    repeat (10) cyc(0);
    rst = 1; tick = 0; btn = 0;
    #2;
    reset_checks("mid_rst");
    @(posedge clk); #1;
    rst = 0;
    mreset();
    round_normal(25, 1);
    repeat (8) begin
      tp = $urandom_range(1, 4);
      case ($urandom_range(0, 4))
        0: round_normal($urandom_range(0, 30), $urandom_range(1, 6));
        1: round_jump_seq($urandom_range(1, 6));
        2: round_jump_delay();
        3: round_final_tick();
        default: round_react_tick();
      endcase
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
